// File: rtl/mmio_output_bank.sv
// ============================================================================
// Module   : mmio_output_bank
// Brief    : Bank of memory-mapped output ports with SET/CLR/TGL aliases and
//            prescaled per-port blink masks. MMIO_OUTPUT_BANK_READBACK_EN
//            enables register readback; otherwise the bank is write-only.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_output_bank #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_WIDTH = 5,
   parameter int BLINK_DIV  = 50000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            cs,
   input  logic                            we,
   input  logic                            re,
   input  logic [ADDR_WIDTH-1:0]           addr,
   input  logic [DATA_WIDTH-1:0]           wdata,
   output logic [DATA_WIDTH-1:0]           rdata,
   output logic                            rdata_valid,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] port_out,
   output logic                            blink_tick
);

   localparam int                c_cnt_w   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(BLINK_DIV - 1);

   logic [c_cnt_w-1:0]    cnt_q, cnt_d;
   logic                  tick_q, tick_d;
   logic                  rdata_valid_q;
   logic [DATA_WIDTH-1:0] port_q [NUM_PORTS];
   logic [DATA_WIDTH-1:0] port_d [NUM_PORTS];
   logic [DATA_WIDTH-1:0] mask_q [NUM_PORTS];
   logic [DATA_WIDTH-1:0] mask_d [NUM_PORTS];
   logic                  w_wr;
   logic                  w_rd;

   assign w_wr = cs & we;
   assign w_rd = cs & re;

   // tick_q is high exactly while the counter sits at its terminal value
   always_comb begin
      cnt_d  = (cnt_q == c_cnt_max) ? '0 : cnt_q + 1'b1;
      tick_d = (cnt_d == c_cnt_max);
   end

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         port_d[p] = port_q[p];
         mask_d[p] = mask_q[p];
         if (tick_q) begin
            port_d[p] = port_q[p] ^ mask_q[p];
         end
         // A CPU write to the port overrides that port's blink toggle
         if (w_wr) begin
            if (addr == ADDR_WIDTH'(4 * p)) begin
               port_d[p] = wdata;
            end
            if (addr == ADDR_WIDTH'(4 * p + 1)) begin
               port_d[p] = port_q[p] | wdata;
            end
            if (addr == ADDR_WIDTH'(4 * p + 2)) begin
               port_d[p] = port_q[p] & ~wdata;
            end
            if (addr == ADDR_WIDTH'(4 * p + 3)) begin
               port_d[p] = port_q[p] ^ wdata;
            end
            if (addr == ADDR_WIDTH'(4 * NUM_PORTS + p)) begin
               mask_d[p] = wdata;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q         <= '0;
         tick_q        <= 1'b0;
         rdata_valid_q <= 1'b0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            port_q[p] <= '0;
            mask_q[p] <= '0;
         end
      end else begin
         cnt_q         <= cnt_d;
         tick_q        <= tick_d;
         rdata_valid_q <= w_rd;
         for (int p = 0; p < NUM_PORTS; p++) begin
            port_q[p] <= port_d[p];
            mask_q[p] <= mask_d[p];
         end
      end
   end

   generate
      for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_out
         assign port_out[g*DATA_WIDTH +: DATA_WIDTH] = port_q[g];
      end
   endgenerate

   assign blink_tick  = tick_q;
   assign rdata_valid = rdata_valid_q;

`ifdef MMIO_OUTPUT_BANK_READBACK_EN
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] w_rd_val;

   // Reads sample the registers before any same-cycle write lands
   always_comb begin
      w_rd_val = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         for (int k = 0; k < 4; k++) begin
            if (addr == ADDR_WIDTH'(4 * p + k)) begin
               w_rd_val = port_q[p];
            end
         end
         if (addr == ADDR_WIDTH'(4 * NUM_PORTS + p)) begin
            w_rd_val = mask_q[p];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (w_rd) begin
         rdata_q <= w_rd_val;
      end
   end

   assign rdata = rdata_q;
`else
   assign rdata = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mmio_output_bank.sv
// ============================================================================
// Module   : tb_mmio_output_bank
// Brief    : Self-checking bench for mmio_output_bank against an operational
//            model of the register bank, with directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_output_bank;

   localparam int DW  = 8;
   localparam int NP  = 4;
   localparam int AW  = 5;
   localparam int DIV = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           cs = 1'b0;
   logic           we = 1'b0;
   logic           re = 1'b0;
   logic [AW-1:0]  addr = '0;
   logic [DW-1:0]  wdata = '0;
   logic [DW-1:0]  rdata;
   logic           rdata_valid;
   logic [NP*DW-1:0] port_out;
   logic           blink_tick;

   mmio_output_bank #(
      .DATA_WIDTH (DW),
      .NUM_PORTS  (NP),
      .ADDR_WIDTH (AW),
      .BLINK_DIV  (DIV)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cs          (cs),
      .we          (we),
      .re          (re),
      .addr        (addr),
      .wdata       (wdata),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .port_out    (port_out),
      .blink_tick  (blink_tick)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Reference model state
   logic [DW-1:0] m_port [NP];
   logic [DW-1:0] m_mask [NP];
   logic [DW-1:0] m_rdata = '0;
   logic          m_valid = 1'b0;
   int            m_n = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] m_read(input int a);
`ifdef MMIO_OUTPUT_BANK_READBACK_EN
      if (a < 4 * NP) return m_port[a / 4];
      if (a < 5 * NP) return m_mask[a - 4 * NP];
      return '0;
`else
      return '0;
`endif
   endfunction

   // Model: applies one bus operation and the blink rule per clock edge
   initial begin
      for (int p = 0; p < NP; p++) begin
         m_port[p] = '0;
         m_mask[p] = '0;
      end
      forever begin
         @(posedge clk);
         if (reset) begin
            for (int p = 0; p < NP; p++) begin
               m_port[p] = '0;
               m_mask[p] = '0;
            end
            m_n = 0;
            m_rdata = '0;
            m_valid = 1'b0;
         end else begin
            int  a;
            bit  tick;
            logic [DW-1:0] old_mask [NP];
            a = int'(addr);
            tick = ((m_n % DIV) == DIV - 1);
            m_valid = cs & re;
            if (cs && re) m_rdata = m_read(a);
            for (int p = 0; p < NP; p++) old_mask[p] = m_mask[p];
            for (int p = 0; p < NP; p++) begin
               if (cs && we && a < 4 * NP && a / 4 == p) begin
                  case (a % 4)
                     0: m_port[p] = wdata;
                     1: m_port[p] = m_port[p] | wdata;
                     2: m_port[p] = m_port[p] & ~wdata;
                     default: m_port[p] = m_port[p] ^ wdata;
                  endcase
               end else if (tick) begin
                  m_port[p] = m_port[p] ^ old_mask[p];
               end
            end
            if (cs && we && a >= 4 * NP && a < 5 * NP) m_mask[a - 4 * NP] = wdata;
            m_n++;
         end
      end
   end

   // Compare process
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int p = 0; p < NP; p++) chk("port_model", 32'(port_out[p*DW +: DW]), 32'(m_port[p]));
            chk("tick_model", 32'(blink_tick), 32'((m_n % DIV) == DIV - 1));
            chk("valid_model", 32'(rdata_valid), 32'(m_valid));
            chk("rdata_model", 32'(rdata), 32'(m_rdata));
         end
      end
   end

   function automatic logic [DW-1:0] pv(input int p);
      return port_out[p*DW +: DW];
   endfunction

   function automatic logic [DW-1:0] rb(input logic [DW-1:0] v);
`ifdef MMIO_OUTPUT_BANK_READBACK_EN
      return v;
`else
      return '0;
`endif
   endfunction

   task automatic do_wr(input int a, input logic [DW-1:0] d);
      cs = 1'b1; we = 1'b1; re = 1'b0; addr = AW'(a); wdata = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic do_rd(input int a);
      cs = 1'b1; we = 1'b0; re = 1'b1; addr = AW'(a);
      @(negedge clk);
      cs = 1'b0; re = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_tick();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2 * DIV + 2; i++) begin
         if (blink_tick) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL tick_timeout: got 0 expected 1 at %0t", $time);
      end
   endtask

   initial begin
      logic [DW-1:0] v;
      logic [DW-1:0] p3;

      // Reset and first write
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;
      chk("reset_ports", 32'(port_out), 32'h0);
      chk("reset_tick", 32'(blink_tick), 32'h0);
      chk("reset_valid", 32'(rdata_valid), 32'h0);
      do_wr(0, 8'hAA);
      chk("p0_data", 32'(pv(0)), 32'hAA);
      chk("others_zero", 32'(port_out[NP*DW-1:DW]), 32'h0);

      // DATA/SET/CLR/TGL aliases on port 1
      do_wr(4, 8'hF0);
      chk("p1_data", 32'(pv(1)), 32'hF0);
      do_wr(5, 8'h0F);
      chk("p1_set", 32'(pv(1)), 32'hFF);
      do_wr(6, 8'h81);
      chk("p1_clr", 32'(pv(1)), 32'h7E);
      do_wr(7, 8'hFF);
      chk("p1_tgl", 32'(pv(1)), 32'h81);
      do_rd(4);
      chk("rd4_valid", 32'(rdata_valid), 32'h1);
      chk("rd4_data", 32'(rdata), 32'(rb(8'h81)));
      @(negedge clk);
      chk("rd4_valid_drop", 32'(rdata_valid), 32'h0);
      chk("rd4_hold", 32'(rdata), 32'(rb(8'h81)));

      // Same-cycle read and write, unmapped accesses
      cs = 1'b1; we = 1'b1; re = 1'b1; addr = AW'(0); wdata = 8'h55;
      @(negedge clk);
      cs = 1'b0; we = 1'b0; re = 1'b0;
      chk("rw_rdata", 32'(rdata), 32'(rb(8'hAA)));
      chk("rw_port0", 32'(pv(0)), 32'h55);
      do_rd(31);
      chk("rd31_data", 32'(rdata), 32'h0);
      chk("rd31_valid", 32'(rdata_valid), 32'h1);
      do_wr(20, 8'hFF);
      chk("unmapped_wr", 32'(port_out), 32'h0000_8155);

      // Blinking port 2 with mask C3
      do_reset();
      do_wr(8, 8'h00);
      do_wr(18, 8'hC3);
      do_rd(18);
      chk("mask_rd", 32'(rdata), 32'(rb(8'hC3)));
      wait_tick();
      v = pv(2);
      chk("blink_base", 32'(v == 8'h00 || v == 8'hC3), 32'h1);
      @(negedge clk);
      chk("blink_toggle", 32'(pv(2)), 32'(v ^ 8'hC3));
      chk("tick_drop", 32'(blink_tick), 32'h0);
      repeat (3) @(negedge clk);
      chk("tick_period", 32'(blink_tick), 32'h1);
      chk("blink_static", 32'(pv(2)), 32'(v ^ 8'hC3));

      // Write on a tick edge overrides only that port's toggle
      do_wr(19, 8'h01);
      wait_tick();
      p3 = pv(3);
      do_wr(8, 8'h11);
      chk("tick_wr_p2", 32'(pv(2)), 32'h11);
      chk("tick_wr_p3", 32'(pv(3)), 32'(p3 ^ 8'h01));

      // Reset mid-blink and mid-read, with a concurrent write
      do_wr(0, 8'h5A);
      reset = 1'b1; cs = 1'b1; we = 1'b1; re = 1'b1; addr = AW'(0); wdata = 8'hFF;
      @(negedge clk);
      reset = 1'b0; cs = 1'b0; we = 1'b0; re = 1'b0;
      chk("rst_ports", 32'(port_out), 32'h0);
      chk("rst_valid", 32'(rdata_valid), 32'h0);
      chk("rst_rdata", 32'(rdata), 32'h0);
      chk("rst_tick", 32'(blink_tick), 32'h0);
      repeat (2 * DIV) @(negedge clk);
      chk("rst_masks", 32'(port_out), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         cs    = ($urandom_range(0, 3) != 0);
         we    = 1'($urandom_range(0, 1));
         re    = 1'($urandom_range(0, 1));
         addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(20, 31))
                                             : AW'($urandom_range(0, 19));
         wdata = DW'($urandom);
         @(negedge clk);
      end
      reset = 1'b0; cs = 1'b0; we = 1'b0; re = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
